// File: rtl/led_phase_scheduler.sv
// Frame sequencer for the optical front end: drives RED, IR and optional dark phases
// on shared LED/PGA/DAC resources, averages an ADC burst per phase, publishes one set per frame.
module led_phase_scheduler #(
    parameter int SETTLE_CYC   = 3,
    parameter int LOG2_SAMPLES = 2,
    parameter bit DARK_EN      = 1'b1
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] RED_PGA,
    input  logic [6:0] RED_DC,
    input  logic [3:0] IR_PGA,
    input  logic [6:0] IR_DC,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [3:0] PGA_Gain,
    output logic [6:0] DC_Comp,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] DARK_ADC_Value,
    output logic       sample_valid,
    output logic       busy,
    output logic [1:0] phase
);
    localparam int N     = 1 << LOG2_SAMPLES;
    localparam int ACC_W = 8 + LOG2_SAMPLES;
    localparam int MAXC  = (SETTLE_CYC > N) ? SETTLE_CYC : N;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ACQ_LAST    = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE, RED_SETTLE, RED_ACQ, IR_SETTLE, IR_ACQ, DARK_SETTLE, DARK_ACQ
    } state_t;

    function automatic logic [7:0] average(input logic [ACC_W-1:0] total);
        return 8'(total >> LOG2_SAMPLES);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       red_hold_q, red_hold_d, ir_hold_q, ir_hold_d;
    logic [7:0]       red_val_q, red_val_d, ir_val_q, ir_val_d, dark_val_q, dark_val_d;
    logic             led_red_q, led_red_d, led_ir_q, led_ir_d;
    logic [3:0]       pga_q, pga_d;
    logic [6:0]       dc_q, dc_d;
    logic             valid_q, valid_d, busy_q, busy_d;
    logic [1:0]       phase_q, phase_d;
    logic [ACC_W-1:0] sum;
    logic [7:0]       avg;
    logic             frame_end;

    // Sum includes the sample taken on this edge, so the last ACQ edge sees the full burst.
    assign sum = acc_q + ACC_W'(ADC);
    assign avg = average(sum);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        red_hold_d = red_hold_q;
        ir_hold_d  = ir_hold_q;
        red_val_d  = red_val_q;
        ir_val_d   = ir_val_q;
        dark_val_d = dark_val_q;
        led_red_d  = 1'b0;
        led_ir_d   = 1'b0;
        pga_d      = pga_q;
        dc_d       = dc_q;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        phase_d    = 2'd0;
        frame_end  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = RED_SETTLE;
            end
            RED_SETTLE, IR_SETTLE, DARK_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (state_q == RED_SETTLE) ? RED_ACQ :
                              (state_q == IR_SETTLE)  ? IR_ACQ  : DARK_ACQ;
                end
            end
            RED_ACQ, IR_ACQ, DARK_ACQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = sum;
                if (cnt_q == ACQ_LAST) begin
                    cnt_d = '0;
                    acc_d = '0;
                    if (state_q == RED_ACQ) begin
                        red_hold_d = avg;
                        state_d    = IR_SETTLE;
                    end else if (state_q == IR_ACQ) begin
                        ir_hold_d = avg;
                        if (DARK_EN) state_d = DARK_SETTLE;
                        else         frame_end = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Publish all three phases together; the final phase's average bypasses its holding register.
        if (frame_end) begin
            red_val_d  = red_hold_q;
            ir_val_d   = DARK_EN ? ir_hold_q : avg;
            dark_val_d = DARK_EN ? avg : 8'd0;
            valid_d    = 1'b1;
            state_d    = enable ? RED_SETTLE : IDLE;
        end

        case (state_d)
            RED_SETTLE, RED_ACQ: begin
                led_red_d = 1'b1;
                phase_d   = 2'd1;
            end
            IR_SETTLE, IR_ACQ: begin
                led_ir_d = 1'b1;
                phase_d  = 2'd2;
            end
            DARK_SETTLE, DARK_ACQ: phase_d = 2'd3;
            default: phase_d = 2'd0;
        endcase
        busy_d = (state_d != IDLE);

        // Analogue settings are latched only when a phase begins, never mid-phase.
        if (state_d != state_q) begin
            if (state_d == RED_SETTLE || state_d == DARK_SETTLE) begin
                pga_d = RED_PGA;
                dc_d  = RED_DC;
            end else if (state_d == IR_SETTLE) begin
                pga_d = IR_PGA;
                dc_d  = IR_DC;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            red_hold_q <= 8'd0;
            ir_hold_q  <= 8'd0;
            red_val_q  <= 8'd0;
            ir_val_q   <= 8'd0;
            dark_val_q <= 8'd0;
            led_red_q  <= 1'b0;
            led_ir_q   <= 1'b0;
            pga_q      <= 4'd0;
            dc_q       <= 7'd127;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            phase_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            red_hold_q <= red_hold_d;
            ir_hold_q  <= ir_hold_d;
            red_val_q  <= red_val_d;
            ir_val_q   <= ir_val_d;
            dark_val_q <= dark_val_d;
            led_red_q  <= led_red_d;
            led_ir_q   <= led_ir_d;
            pga_q      <= pga_d;
            dc_q       <= dc_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            phase_q    <= phase_d;
        end
    end

    assign LED_RED        = led_red_q;
    assign LED_IR         = led_ir_q;
    assign PGA_Gain       = pga_q;
    assign DC_Comp        = dc_q;
    assign RED_ADC_Value  = red_val_q;
    assign IR_ADC_Value   = ir_val_q;
    assign DARK_ADC_Value = dark_val_q;
    assign sample_valid   = valid_q;
    assign busy           = busy_q;
    assign phase          = phase_q;
endmodule
